// File: rtl/i2s_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_transmitter
//
// Mono I2S / left-justified serial transmitter slaved to an external bit
// clock and word select. A single sample register feeds both the left and
// right slot of each frame. bclk and lrclk are sampled in the clk_i domain,
// so all serial timing is derived from synchronized edge detects.
//
// Parameters
//   DATA_WIDTH  sample width in bits (1..32)
//   I2S_FORMAT  "True" = Philips I2S (MSB one bclk after the lrclk edge),
//               anything else = left-justified (MSB on the lrclk edge)
//
// Ports
//   clk_i       system clock
//   arst_i      asynchronous active-high reset
//   bclk_i      external bit clock (asynchronous)
//   lrclk_i     external word select, 0 = left, 1 = right (asynchronous)
//   sdata_o     registered serial data to the DAC
//   data_i      two's complement sample
//   data_val_i  one-cycle strobe qualifying data_i
//   underrun_o  one-cycle pulse: a frame began without a fresh sample
//   overrun_o   one-cycle pulse: a held sample was overwritten unsent
// ---------------------------------------------------------------------------
module i2s_transmitter #(
    parameter int DATA_WIDTH = 16,
    parameter     I2S_FORMAT = "True"
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  bclk_i,
    input  logic                  lrclk_i,
    output logic                  sdata_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_val_i,
    output logic                  underrun_o,
    output logic                  overrun_o
);

    localparam logic       IS_I2S    = (I2S_FORMAT == "True");
    localparam int         PAD_BITS  = 32 - DATA_WIDTH;
    localparam logic [5:0] SLOT_BITS = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_bclk_sync;
    logic [2:0]            r_lr_sync;
    logic                  w_bclk_fall;
    logic                  w_lr_fall;
    logic                  w_lr_rise;
    logic                  w_frame_start;
    logic                  w_slot_start;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_frame;
    logic [DATA_WIDTH-1:0] w_frame_next;
    logic [31:0]           w_slot_word;
    logic [31:0]           r_shift;
    logic [5:0]            r_bit_cnt;
    logic                  r_sdata;
    logic                  r_underrun;
    logic                  r_overrun;

    // Two metastability stages plus one history stage per external clock.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_bclk_sync <= 3'b000;
            r_lr_sync   <= 3'b000;
        end else begin
            r_bclk_sync <= {r_bclk_sync[1:0], bclk_i};
            r_lr_sync   <= {r_lr_sync[1:0], lrclk_i};
        end
    end

    // Edges are taken between the last two stages so bclk and lrclk see
    // identical latency.
    assign w_bclk_fall = r_bclk_sync[2] & ~r_bclk_sync[1];
    assign w_lr_fall   = r_lr_sync[2]   & ~r_lr_sync[1];
    assign w_lr_rise   = ~r_lr_sync[2]  &  r_lr_sync[1];

    // Slot state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Slot sequencing; a word-select edge of the wrong polarity is ignored.
    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_slot_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_lr_fall) begin
                    w_state_next  = ST_LEFT;
                    w_frame_start = 1'b1;
                    w_slot_start  = 1'b1;
                end else begin
                    w_state_next  = ST_IDLE;
                end
            end
            ST_LEFT: begin
                if (w_lr_rise) begin
                    w_state_next  = ST_RIGHT;
                    w_slot_start  = 1'b1;
                end else begin
                    w_state_next  = ST_LEFT;
                end
            end
            ST_RIGHT: begin
                if (w_lr_fall) begin
                    w_state_next  = ST_LEFT;
                    w_frame_start = 1'b1;
                    w_slot_start  = 1'b1;
                end else begin
                    w_state_next  = ST_RIGHT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The frame load sees the holding register as it was before any strobe
    // in the same cycle; an empty holding register repeats the last sample.
    assign w_frame_next = (w_frame_start && r_hold_full) ? r_hold : r_frame;

    // Sample left-aligned in the 32-bit slot, zero padded below.
    assign w_slot_word = 32'(w_frame_next) << PAD_BITS;

    // Holding register, frame sample and status pulses.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_frame     <= '0;
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame    <= w_frame_next;
            r_underrun <= w_frame_start & ~r_hold_full;
            // A strobe landing on a frame start is not an overrun: the old
            // content is consumed by the frame in that same cycle.
            r_overrun  <= data_val_i & r_hold_full & ~w_frame_start;
            if (data_val_i) begin
                r_hold      <= data_i;
                r_hold_full <= 1'b1;
            end else if (w_frame_start) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Serializer. r_bit_cnt counts bits already driven in the current slot;
    // left-justified drives the MSB in the edge cycle itself, so it starts
    // at one, while I2S holds the previous bit until the next bclk fall.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_shift   <= 32'd0;
            r_bit_cnt <= 6'd0;
            r_sdata   <= 1'b0;
        end else if (w_slot_start) begin
            if (IS_I2S) begin
                r_shift   <= w_slot_word;
                r_bit_cnt <= 6'd0;
            end else begin
                r_shift   <= {w_slot_word[30:0], 1'b0};
                r_bit_cnt <= 6'd1;
                r_sdata   <= w_slot_word[31];
            end
        end else if (r_state == ST_IDLE) begin
            r_bit_cnt <= 6'd0;
            r_sdata   <= 1'b0;
        end else if (w_bclk_fall) begin
            if (r_bit_cnt < SLOT_BITS) begin
                r_sdata   <= r_shift[31];
                r_shift   <= {r_shift[30:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end else begin
                r_sdata   <= 1'b0;
            end
        end
    end

    assign sdata_o    = r_sdata;
    assign underrun_o = r_underrun;
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// ---------------------------------------------------------------------------
// tb_i2s_transmitter
//
// Drives one I2S-format and one left-justified instance from a shared
// bclk/lrclk master (bclk = clk/8, 32 bclk per slot). A sample-level model
// (holding register, frame sample, cumulative underrun/overrun counts)
// pushes the expected 32-bit word of every slot and the expected pulse
// totals into queues; per-instance monitors deserialize sdata and compare.
// Left-justified bits are taken in bclk periods 0..31 of a slot; the I2S
// stream is the same stream delayed by one bclk.
// ---------------------------------------------------------------------------
module tb_i2s_transmitter;

    logic        clk;
    logic        arst;
    logic        bclk;
    logic        lrclk;
    logic [15:0] data_in;
    logic        data_val;
    logic        sdata_i2s, sdata_lj;
    logic        under_i2s, under_lj;
    logic        over_i2s, over_lj;

    int n_vec = 0;
    int n_bad = 0;

    // model state
    logic [15:0] m_hold  = 16'h0000;
    bit          m_hold_v = 1'b0;
    logic [15:0] m_frame = 16'h0000;
    bit          m_active = 1'b0;
    int          m_under = 0;
    int          m_over  = 0;
    bit          sb_on   = 1'b0;

    logic [32:0] q_word_lj[$];
    logic [32:0] q_word_i2s[$];
    logic [31:0] q_cnt_lj[$];
    logic [31:0] q_cnt_i2s[$];

    int nu_lj = 0, no_lj = 0, nu_i2s = 0, no_i2s = 0;

    i2s_transmitter #(.DATA_WIDTH(16), .I2S_FORMAT("True")) u_i2s (
        .clk_i(clk), .arst_i(arst), .bclk_i(bclk), .lrclk_i(lrclk),
        .sdata_o(sdata_i2s), .data_i(data_in), .data_val_i(data_val),
        .underrun_o(under_i2s), .overrun_o(over_i2s)
    );

    i2s_transmitter #(.DATA_WIDTH(16), .I2S_FORMAT("Left")) u_lj (
        .clk_i(clk), .arst_i(arst), .bclk_i(bclk), .lrclk_i(lrclk),
        .sdata_o(sdata_lj), .data_i(data_in), .data_val_i(data_val),
        .underrun_o(under_lj), .overrun_o(over_lj)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_frame_start();
        if (m_hold_v) begin
            m_frame  = m_hold;
            m_hold_v = 1'b0;
        end else begin
            m_under++;
        end
        m_active = 1'b1;
    endtask

    task automatic m_strobe(input logic [15:0] d);
        if (m_hold_v) m_over++;
        m_hold   = d;
        m_hold_v = 1'b1;
    endtask

    task automatic m_reset();
        m_hold   = 16'h0000;
        m_hold_v = 1'b0;
        m_frame  = 16'h0000;
        m_active = 1'b0;
    endtask

    // One 32-bclk slot. sp: period of a mid-slot strobe (-1 none);
    // coinc: strobe on the frame-start cycle; rp: period of a reset pulse.
    task automatic gen_slot(input logic lr, input int sp, input logic [15:0] sd,
                            input bit coinc, input logic [15:0] cd, input int rp);
        bit          had;
        logic [31:0] w;
        had = sb_on;
        if (lr == 1'b0) begin
            m_frame_start();
            sb_on = 1'b1;
        end
        if (had) begin
            q_cnt_lj.push_back({16'(m_under), 16'(m_over)});
            q_cnt_i2s.push_back({16'(m_under), 16'(m_over)});
        end
        if (coinc) m_strobe(cd);
        if (sb_on) begin
            w = m_active ? {m_frame, 16'h0000} : 32'h0000_0000;
            q_word_lj.push_back({(rp < 0), w});
            q_word_i2s.push_back({(rp < 0), w});
        end
        lrclk = lr;
        for (int p = 0; p < 32; p++) begin
            bclk = 1'b0;
            if (p == 0 && coinc) begin
                #16 data_in = cd; data_val = 1'b1;
                #10 data_val = 1'b0;
                #14;
            end else if (p == sp) begin
                #21 data_in = sd; data_val = 1'b1;
                m_strobe(sd);
                #10 data_val = 1'b0;
                #9;
            end else if (p == rp) begin
                #21 arst = 1'b1;
                m_reset();
                #1;
                check("rst_sdata_i2s", 32'(sdata_i2s), 32'd0);
                check("rst_sdata_lj", 32'(sdata_lj), 32'd0);
                #8 arst = 1'b0;
                #10;
            end else begin
                #40;
            end
            bclk = 1'b1;
            #40;
        end
    endtask

    // ---------------- monitors ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (under_lj)  nu_lj++;
            if (over_lj)   no_lj++;
            if (under_i2s) nu_i2s++;
            if (over_i2s)  no_i2s++;
        end
    end

    task automatic slot_end(input string tag, input logic [31:0] word, input bit is_i2s);
        logic [32:0] we;
        logic [31:0] ce;
        if (is_i2s ? (q_word_i2s.size() == 0 || q_cnt_i2s.size() == 0)
                   : (q_word_lj.size() == 0 || q_cnt_lj.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_queue: got empty expected entry at %0t", tag, $time);
        end else begin
            we = is_i2s ? q_word_i2s.pop_front() : q_word_lj.pop_front();
            ce = is_i2s ? q_cnt_i2s.pop_front()  : q_cnt_lj.pop_front();
            if (we[32]) check({tag, "_slot"}, word, we[31:0]);
            check({tag, "_underruns"}, is_i2s ? 32'(nu_i2s) : 32'(nu_lj), 32'(ce[31:16]));
            check({tag, "_overruns"},  is_i2s ? 32'(no_i2s) : 32'(no_lj), 32'(ce[15:0]));
        end
    endtask

    logic [31:0] col_lj = 32'd0, col_i2s = 32'd0;
    logic        prev_lj = 1'b1, prev_i2s = 1'b1;
    bit          st_lj = 1'b0, st_i2s = 1'b0;

    initial begin
        forever begin
            @(posedge bclk);
            if (lrclk !== prev_lj) begin
                if (st_lj) slot_end("lj", col_lj, 1'b0);
                st_lj  = 1'b1;
                col_lj = 32'd0;
            end
            prev_lj = lrclk;
            col_lj  = {col_lj[30:0], sdata_lj};
        end
    end

    initial begin
        logic s;
        forever begin
            @(posedge bclk);
            s = sdata_i2s;
            if (lrclk !== prev_i2s) begin
                if (st_i2s) slot_end("i2s", {col_i2s[30:0], s}, 1'b1);
                st_i2s  = 1'b1;
                col_i2s = 32'd0;
            end else begin
                col_i2s = {col_i2s[30:0], s};
            end
            prev_i2s = lrclk;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          sp;
        bit          co;
        logic [15:0] sd, cd;
        arst     = 1'b0;
        bclk     = 1'b1;
        lrclk    = 1'b1;
        data_val = 1'b0;
        data_in  = 16'h0000;
        #1 arst = 1'b1;
        #7;
        check("reset_sdata_i2s", 32'(sdata_i2s), 32'd0);
        check("reset_sdata_lj", 32'(sdata_lj), 32'd0);
        check("reset_underrun", 32'({under_i2s, under_lj}), 32'd0);
        check("reset_overrun", 32'({over_i2s, over_lj}), 32'd0);
        #25 arst = 1'b0;
        #7;
        // preamble right slot (DUT idle), sample written before first frame
        gen_slot(1'b1, 5, 16'hA5C3, 1'b0, 16'h0, -1);
        // frame 1: A5C3; next sample 7FFF
        gen_slot(1'b0, 8, 16'h7FFF, 1'b0, 16'h0, -1);
        gen_slot(1'b1, -1, 16'h0, 1'b0, 16'h0, -1);
        // frames 2..4: 7FFF, then repeated with underruns
        for (int f = 0; f < 2; f++) begin
            gen_slot(1'b0, -1, 16'h0, 1'b0, 16'h0, -1);
            gen_slot(1'b1, -1, 16'h0, 1'b0, 16'h0, -1);
        end
        // frame 4: two strobes -> one overrun
        gen_slot(1'b0, 4, 16'h0001, 1'b0, 16'h0, -1);
        gen_slot(1'b1, 10, 16'h8000, 1'b0, 16'h0, -1);
        // frame 5: 8000, then 1234 held
        gen_slot(1'b0, 6, 16'h1234, 1'b0, 16'h0, -1);
        gen_slot(1'b1, -1, 16'h0, 1'b0, 16'h0, -1);
        // frame 6: strobe coincident with frame start
        gen_slot(1'b0, -1, 16'h0, 1'b1, 16'h4321, -1);
        gen_slot(1'b1, -1, 16'h0, 1'b0, 16'h0, -1);
        // frame 7: reset mid left slot
        gen_slot(1'b0, -1, 16'h0, 1'b0, 16'h0, 10);
        gen_slot(1'b1, -1, 16'h0, 1'b0, 16'h0, -1);
        // frame 8: silent frame with underrun
        gen_slot(1'b0, -1, 16'h0, 1'b0, 16'h0, -1);
        gen_slot(1'b1, -1, 16'h0, 1'b0, 16'h0, -1);
        // random frames
        for (int f = 0; f < 12; f++) begin
            for (int s = 0; s < 2; s++) begin
                sp = ($urandom_range(1, 0) == 1) ? int'($urandom_range(28, 2)) : -1;
                sd = 16'($urandom);
                cd = 16'($urandom);
                co = (s == 0) && ($urandom_range(3, 0) == 0);
                gen_slot(s[0], sp, sd, co, cd, -1);
            end
        end
        gen_slot(1'b0, -1, 16'h0, 1'b0, 16'h0, -1);
        check("drain_words_lj", 32'(q_word_lj.size()), 32'd1);
        check("drain_cnt_lj", 32'(q_cnt_lj.size()), 32'd0);
        check("drain_words_i2s", 32'(q_word_i2s.size()), 32'd1);
        check("drain_cnt_i2s", 32'(q_cnt_i2s.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width in bits, legal range 1..32.
REQ-002 Parameter I2S_FORMAT, default "True": "True" selects Philips I2S, where the MSB is one bclk after the lrclk edge; any other value selects left-justified, where the MSB is on the lrclk edge.
REQ-003 clk_i  input  1  system clock; all logic is in this single domain.
REQ-004 arst_i  input  1  asynchronous active-high reset.
REQ-005 bclk_i  input  1  I2S bit clock from the external master; asynchronous to clk_i.
REQ-006 lrclk_i  input  1  I2S word select; 0 = left slot, 1 = right slot; asynchronous.
REQ-007 sdata_o  output  1  serial data to the DAC, registered.
REQ-008 data_i  input  DATA_WIDTH  sample to transmit, two's complement.
REQ-009 data_val_i  input  1  one-cycle strobe; data_i is valid in that cycle.
REQ-010 underrun_o  output  1  one-cycle pulse: a frame started with no fresh sample.
REQ-011 overrun_o  output  1  one-cycle pulse: a sample was overwritten before it was sent.

Function
REQ-012 bclk_i and lrclk_i SHALL each pass through a 2-flop synchronizer plus one history flop; edge detects use the last two synchronized stages, giving equal latency for both signals.
REQ-013 bclk_fall SHALL be true when the synchronized bclk goes 1->0; lr_fall and lr_rise SHALL be defined the same way for the synchronized lrclk.
REQ-014 Holding register: on data_val_i, data_i SHALL be stored and hold_full set to 1.
REQ-015 If data_val_i arrives while hold_full=1, the new data SHALL overwrite the stored sample and overrun_o SHALL pulse in the following cycle.
REQ-016 FSM states SHALL be IDLE, LEFT and RIGHT.
REQ-017 FSM transitions:
- IDLE -> LEFT on lr_fall.
- LEFT -> RIGHT on lr_rise.
- RIGHT -> LEFT on lr_fall.
- A lrclk edge of the wrong polarity for the current state SHALL be ignored.
REQ-018 On every lr_fall (start of a frame), the frame sample SHALL be loaded:
- hold_full=1: load the holding register into frame_reg and clear hold_full.
- hold_full=0: keep the previous frame_reg and pulse underrun_o.
REQ-019 If data_val_i coincides with lr_fall, the frame load SHALL use the old holding content, and the new sample SHALL remain held with hold_full=1.
REQ-020 The same frame_reg SHALL be transmitted in both the left and right slots (mono).
REQ-021 On each lrclk edge, a 32-bit slot shift register SHALL be loaded with {frame_reg, (32-DATA_WIDTH) zeros}, MSB first, and bit_cnt SHALL be cleared.
REQ-022 Left-justified format: on the edge cycle sdata_o SHALL take the MSB; on each later bclk_fall it SHALL take the next bit.
REQ-023 I2S format: on the edge cycle sdata_o SHALL keep the last bit of the previous slot; the MSB SHALL be driven on the first bclk_fall after the edge, and the following bits on each later bclk_fall.
REQ-024 After 32 bits have been driven in a slot, sdata_o SHALL be 0 until the next lrclk edge; bit_cnt SHALL saturate at 32.
REQ-025 sdata_o SHALL be 0 while in IDLE.
REQ-026 A lrclk edge arriving mid-slot SHALL abort the current slot and restart per REQ-021 (resync).

Reset
REQ-027 While arst_i=1, the module SHALL hold:
- state = IDLE;
- sdata_o = 0, underrun_o = 0, overrun_o = 0;
- hold_full = 0;
- frame_reg, holding register and shift register = 0;
- bit_cnt = 0;
- synchronizer flops = 0.
REQ-028 After reset is released, no bit SHALL be driven until the first lr_fall.
REQ-029 Reset asserted mid-frame SHALL take effect immediately; the output SHALL return to sdata_o=0 within the same clk_i cycle.

Verification
REQ-030 Philips I2S, DATA_WIDTH=16, bclk=clk/8, 64 bclk per frame, data_i=16'hA5C3 written before lr_fall -> left and right slots each carry 1010_0101_1100_0011 followed by 16 zeros, MSB one bclk after the lrclk edge.
REQ-031 Left-justified, same stimulus -> MSB coincides with the lrclk edge; the bit stream is otherwise identical.
REQ-032 No data_val_i for 2 frames after sample 16'h7FFF -> 16'h7FFF is repeated in both frames, with one underrun_o pulse per frame.
REQ-033 Two data_val_i strobes (16'h0001 then 16'h8000) within one frame -> one overrun_o pulse; the next frame carries 16'h8000.
REQ-034 data_val_i coincident with lr_fall -> the old sample goes out this frame and the new sample goes out next frame; no underrun_o or overrun_o.
REQ-035 arst_i pulsed mid-left-slot -> sdata_o=0 immediately; output stays silent until the next lr_fall; hold_full=0, so the first frame after reset pulses underrun_o and carries 0.
